seq_divider24: RTL and testbench

SEQ_DIVIDER24 -- requirements
Module: seq_divider24

---
 rtl/seq_divider24.sv | 133 +++++++++++++
 tb/tb_seq_divider24.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider24.sv
// rtl/seq_divider24.sv - 24-bit restoring sequential divider with ripple-carry trial subtractor
// One quotient bit per RUN cycle, MSB first; divide-by-zero bypasses RUN with a saturated quotient.

module ripple24 (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic        cin_i,
    output logic [23:0] sum_o,
    output logic        cout_o
);
    logic [24:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < 24; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[24];
endmodule

module seq_divider24 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] A,
    input  logic [23:0] B,
    output logic [23:0] Q,
    output logic [23:0] R,
    output logic        busy,
    output logic        done,
    output logic        dbz
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q;
    logic [23:0] dvd_q;
    logic [23:0] b_q;
    logic [23:0] rem_q;
    logic [4:0]  cnt_q;
    logic [23:0] q_q;
    logic [23:0] r_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic [24:0] t;
    logic [23:0] diff;
    logic        no_borrow;
    logic        qb;
    logic [23:0] rem_d;
    logic [23:0] quo_d;

    // Dividend register doubles as the quotient shift register: its MSB feeds
    // the remainder while quotient bits enter at the LSB.
    assign t = {rem_q, dvd_q[23]};

    ripple24 u_sub (
        .a_i    (t[23:0]),
        .b_i    (~b_q),
        .cin_i  (1'b1),
        .sum_o  (diff),
        .cout_o (no_borrow)
    );

    assign qb    = t[24] | no_borrow;
    assign rem_d = qb ? diff : t[23:0];
    assign quo_d = {dvd_q[22:0], qb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        if (B != 24'd0) begin
                            dvd_q   <= A;
                            b_q     <= B;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            q_q     <= 24'hFFFFFF;
                            r_q     <= A;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                RUN: begin
                    dvd_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        q_q     <= quo_d;
                        r_q     <= rem_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
endmodule

// File: tb/tb_seq_divider24.sv
// tb/tb_seq_divider24.sv - directed and random scoreboard bench for seq_divider24

module tb_seq_divider24;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] A = '0;
    logic [23:0] B = '0;
    logic [23:0] Q;
    logic [23:0] R;
    logic        busy;
    logic        done;
    logic        dbz;

    int n_vec = 0;
    int n_err = 0;
    logic [48:0] sb[$];

    seq_divider24 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] model(input logic [23:0] a, input logic [23:0] b);
        if (b == 24'd0) return {24'hFFFFFF, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", {63'd0, done}, 64'd0);
            else chk("result", {15'd0, Q, R, dbz}, {15'd0, sb.pop_front()});
        end
    end

    task automatic start_op(input logic [23:0] a, input logic [23:0] b, input bit expect_result);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        if (expect_result) sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_results(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int bc;
        int lat;
        int gap;
        logic [23:0] ra;
        logic [23:0] rb;

        #1;
        chk("reset_outs", {15'd0, Q, R, dbz}, 64'd0);
        chk("reset_ctl", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 100/7 with busy/done latency profile
        start_op(24'd100, 24'd7, 1'b1);
        bc = 0; lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        chk("busy_cycles", 64'(bc), 64'd24);
        chk("done_latency", 64'(lat), 64'd24);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        wait_results(50);

        start_op(24'hFFFFFF, 24'd1, 1'b1);
        wait_results(50);
        start_op(24'd5, 24'd10, 1'b1);
        wait_results(50);
        start_op(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        wait_results(50);

        // divide by zero: done right after the accepting edge, no RUN
        start_op(24'd1234, 24'd0, 1'b1);
        chk("dbz_busy", {63'd0, busy}, 64'd0);
        wait_results(5);
        @(negedge clk);
        chk("dbz_hold", {15'd0, Q, R, dbz}, {15'd0, 24'hFFFFFF, 24'd1234, 1'b1});

        // start while busy is ignored
        start_op(24'd1000, 24'd3, 1'b1);
        repeat (8) @(negedge clk);
        A = 24'd9; B = 24'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_results(50);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-run
        start_op(24'd50, 24'd5, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_outs", {15'd0, Q, R, dbz}, 64'd0);
        chk("rst_async_ctl", {62'd0, busy, done}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        A = 24'd50; B = 24'd5; start = 1'b1;
        sb.push_back(model(24'd50, 24'd5));
        @(negedge clk);
        start = 1'b0;
        wait_results(50);

        // back-to-back with start held high
        @(negedge clk);
        A = 24'd123456; B = 24'd789; start = 1'b1;
        sb.push_back(model(A, B));
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (done !== 1'b1 && gap < 60);
            chk("b2b_gap", 64'(gap), 64'd25);
            if (k < 2) sb.push_back(model(A, B));
            else start = 1'b0;
        end
        wait_results(50);

        // random back-to-back stream against the golden model
        @(negedge clk);
        for (int i = 0; i < 1500; i++) begin
            ra = 24'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 24'd0;
                1, 2: rb = 24'($urandom_range(1, 255));
                default: rb = 24'($urandom);
            endcase
            A = ra; B = rb; start = 1'b1;
            sb.push_back(model(ra, rb));
            repeat ((rb == 24'd0) ? 1 : 25) @(negedge clk);
        end
        start = 1'b0;
        wait_results(60);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
